// File: rtl/con_poller.sv
// Serial game-controller poller: latches all pads, shifts BITS_PER_CON bits from each, and publishes the frame atomically.
// Optional change interrupt is built only when CON_CHANGE_IRQ_EN is defined.
module con_poller #(
  parameter int NUM_CON      = 2,
  parameter int BITS_PER_CON = 16,
  parameter int HALF_CYC     = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            poll_en,
  output logic                            con_latch,
  output logic                            con_clk,
  input  logic [NUM_CON-1:0]              con_data,
  output logic [NUM_CON*BITS_PER_CON-1:0] con_state,
  output logic                            state_valid,
  output logic                            change_irq,
  input  logic                            irq_ack
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(2 * HALF_CYC);
  localparam int BW = $clog2(BITS_PER_CON);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_CON - 1);

  typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t                            r_state;
  state_t                            w_next;
  logic [TW-1:0]                     r_timer;
  logic [CW-1:0]                     r_cnt;
  logic [BW-1:0]                     r_bit;
  logic [NUM_CON-1:0]                r_sync1;
  logic [NUM_CON-1:0]                r_sync2;
  logic [BITS_PER_CON-1:0]           r_shift [NUM_CON];
  logic [NUM_CON*BITS_PER_CON-1:0]   w_shift_flat;
  logic [NUM_CON*BITS_PER_CON-1:0]   r_con_state;
  logic                              w_tick;
  logic                              w_capture;
  logic                              w_load;

  assign w_tick = (r_timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_timer <= w_tick ? '0 : r_timer + 1'b1;
      r_sync1 <= con_data;
      r_sync2 <= r_sync1;
    end
  end

  // Ticks arriving outside IDLE simply fall through; nothing is queued.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE:     if (w_tick && poll_en) w_next = LATCH;
      LATCH:    if (r_cnt == LATCH_LAST) w_next = SHIFT_LO;
      SHIFT_LO: if (r_cnt == HALF_LAST) begin
                  w_capture = 1'b1;
                  w_next    = SHIFT_HI;
                end
      SHIFT_HI: if (r_cnt == HALF_LAST) w_next = (r_bit == BIT_LAST) ? DONE : SHIFT_LO;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Publishing on the edge into DONE makes con_state new exactly while state_valid is high.
  assign w_load      = (r_state == SHIFT_HI) && (w_next == DONE);
  assign con_latch   = (r_state == LATCH);
  assign con_clk     = (r_state != SHIFT_LO);
  assign state_valid = (r_state == DONE);
  assign con_state   = r_con_state;

  always_comb begin
    w_shift_flat = '0;
    for (int k = 0; k < NUM_CON; k++) w_shift_flat[k*BITS_PER_CON +: BITS_PER_CON] = r_shift[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_con_state <= '0;
      for (int k = 0; k < NUM_CON; k++) r_shift[k] <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= ((w_next != r_state) || (r_state == IDLE)) ? '0 : r_cnt + 1'b1;
      if (r_state == LATCH) r_bit <= '0;
      else if ((r_state == SHIFT_HI) && (w_next == SHIFT_LO)) r_bit <= r_bit + 1'b1;
      // Pad data is active-low; store 1 = pressed.
      if (w_capture) begin
        for (int k = 0; k < NUM_CON; k++) r_shift[k][r_bit] <= ~r_sync2[k];
      end
      if (w_load) r_con_state <= w_shift_flat;
    end
  end

`ifdef CON_CHANGE_IRQ_EN
  logic r_irq;
  logic w_changed;

  assign w_changed = w_load && (w_shift_flat != r_con_state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_irq <= 1'b0;
    else if (w_changed) r_irq <= 1'b1;
    else if (irq_ack)   r_irq <= 1'b0;
  end

  assign change_irq = r_irq;
`else
  logic w_unused_ack;

  assign w_unused_ack = irq_ack;
  assign change_irq   = 1'b0;
`endif

endmodule

// File: doc/con_poller.md
CON_POLLER -- requirements
Module: con_poller

Interface
REQ-001 The block SHALL expose parameter NUM_CON, default 2, number of serial game controllers polled in parallel (1..4).
REQ-002 The block SHALL expose parameter BITS_PER_CON, default 16, button bits shifted per controller per frame (8..32).
REQ-003 The block SHALL expose parameter HALF_CYC, default 300, clk cycles per half-period of con_clk and per latch half-period (>=2).
REQ-004 The block SHALL expose parameter POLL_CYCLES, default 833333, clk cycles between poll starts (must exceed frame length).
REQ-005 The block SHALL have ports, with clk and rst first:
- clk  in  1  system clock (50 MHz); the block uses one clock only
- rst  in  1  asynchronous, active-high reset
- poll_en  in  1  enables periodic polling
- con_latch  out  1  latch strobe to all controllers
- con_clk  out  1  shift clock to all controllers, idles high
- con_data  in  NUM_CON  serial data, active-low, one bit per controller
- con_state  out  NUM_CON*BITS_PER_CON  button state, 1 = pressed; controller k at bits [k*BITS_PER_CON +: BITS_PER_CON]
- state_valid  out  1  one-cycle pulse when con_state is updated
- change_irq  out  1  sticky flag, set when any button state changes
- irq_ack  in  1  clears change_irq

Function
REQ-006 con_data SHALL pass through a 2-flop synchronizer before use; all sampling SHALL use the synchronized value.
REQ-007 A free-running poll timer SHALL count 0..POLL_CYCLES-1 and wrap, issuing a tick on the wrap cycle.
REQ-008 The FSM SHALL have states IDLE, LATCH, SHIFT_LO, SHIFT_HI and DONE.
REQ-009 In IDLE, on a tick with poll_en=1, the FSM SHALL enter LATCH; a tick received outside IDLE SHALL be dropped, not queued.
REQ-010 In LATCH, con_latch SHALL be 1 for 2*HALF_CYC cycles, followed by SHIFT_LO with bit index 0.
REQ-011 In SHIFT_LO, con_clk SHALL be 0 for HALF_CYC cycles; on the last of these cycles, bit i of each controller SHALL be captured as the inverted synchronized con_data[k].
REQ-012 In SHIFT_HI, con_clk SHALL be 1 for HALF_CYC cycles; the FSM SHALL then enter SHIFT_LO with i+1, or DONE if i = BITS_PER_CON-1.
REQ-013 DONE SHALL last 1 cycle: con_state SHALL be loaded atomically from the shift registers, state_valid SHALL pulse, and the FSM SHALL return to IDLE.
REQ-014 Frame length SHALL be exactly 2*HALF_CYC*(BITS_PER_CON+1)+1 cycles from leaving IDLE to re-entering IDLE.
REQ-015 con_state SHALL NOT change outside the DONE cycle; partial frames SHALL never be visible.
REQ-016 Deasserting poll_en mid-frame SHALL let the current frame complete; no new frame SHALL start until poll_en=1 and a tick occurs.
REQ-017 Outside LATCH, con_latch SHALL be 0; outside SHIFT_LO, con_clk SHALL be 1.

Reset
REQ-018 While rst=1, outputs SHALL be: con_latch=0, con_clk=1, con_state=0, state_valid=0, change_irq=0; the FSM SHALL be in IDLE, the poll timer at 0, and the synchronizers cleared.
REQ-019 rst asserted mid-frame SHALL abort the frame immediately; no partial data SHALL reach con_state.
REQ-020 After rst falls, the first frame SHALL start at the first tick, POLL_CYCLES-1 cycles later, if poll_en=1.

Configuration
REQ-021 With macro CON_CHANGE_IRQ_EN defined, change_irq SHALL set on any DONE cycle where the new con_state differs from the previous value, and SHALL clear on irq_ack=1.
REQ-022 With CON_CHANGE_IRQ_EN defined, a set and an irq_ack in the same cycle SHALL leave change_irq=1 (set wins).
REQ-023 Without CON_CHANGE_IRQ_EN, change_irq SHALL be constant 0, irq_ack SHALL be ignored, and no comparison logic SHALL be built.

Verification (NUM_CON=2, BITS_PER_CON=16, HALF_CYC=4, POLL_CYCLES=1000)
REQ-024 Controller models drive 0xFFFE (ctl0) and 0x7FFF (ctl1), active-low -> after DONE, con_state=0x8000_0001, state_valid high for exactly 1 cycle, frame length 137 cycles.
REQ-025 Monitor con_latch/con_clk over one frame -> latch high 8 cycles, then 16 low pulses of 4 cycles each, con_clk high otherwise.
REQ-026 Macro defined; same data on two frames, then ctl0 bit 3 is pressed -> change_irq=0 after frame 2 and 1 after frame 3; irq_ack pulse -> 0; irq_ack coincident with a new change -> stays 1.
REQ-027 Drop poll_en at cycle 50 of a frame -> frame completes with valid con_state; no further latch pulse for 3000 cycles.
REQ-028 Assert rst at cycle 70 of a frame for 2 cycles -> con_state=0, con_latch=0, con_clk=1 immediately; the next frame starts 999 cycles after release.
REQ-029 Macro undefined; button changes and irq_ack toggling -> change_irq constantly 0.
